// File: rtl/apb_uart_csr_pkg.sv
// Shared definitions for the APB UART register block:
// register offsets, CTRL/STATUS bit positions and the bus FSM states.
package apb_uart_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_BAUD   = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_TXDATA = 5'h0C;
  localparam logic [4:0] OFF_RXDATA = 5'h10;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_RX_IRQ = 2;
  localparam int CTRL_TX_IRQ = 3;

  localparam int ST_OVERRUN = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_uart_csr_if.sv
// APB3 bus bundle between the initiator and the UART
// register block.
interface apb_uart_csr_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_csr_sync_fifo.sv
// Single-clock byte FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/apb_uart_csr.sv
// APB3 completer for the UART: CTRL/BAUD/STATUS registers
// plus TX and RX byte FIFOs, with configurable wait states.
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int BAUD_RST    = 868
) (
  input  logic                clk,
  input  logic                rst,
  apb_uart_csr_if.slave       apb,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [15:0]         baud_div,
  output logic                rx_en,
  output logic                irq
);
  localparam int CW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  apb_state_t      state;
  logic [CW-1:0]   wcnt;
  logic [3:0]      ctrl;
  logic            overrun;
  logic            pready;
  logic [4:0]      off;
  logic            legal;
  logic            is_wr;
  logic            is_rd;
  logic            err;
  logic [31:0]     rd_word;
  logic            tx_full, tx_empty, tx_push, tx_pop;
  logic            rx_full, rx_empty, rx_push, rx_pop;
  logic            rx_ovr;
  logic [7:0]      rx_head;
  logic [TCW-1:0]  tx_count;
  logic [RCW-1:0]  rx_count;
  logic            unused_bits;

  assign unused_bits = ^{apb.paddr[31:5], apb.pwdata[31:16], tx_count};

  assign pready = (state == ACCESS) & apb.psel & apb.penable
                & (wcnt == CW'(WAIT_STATES));

  assign off   = apb.paddr[4:0];
  assign legal = (apb.paddr[1:0] == 2'b00) && (off <= OFF_RXDATA);
  assign is_wr = pready & apb.pwrite;
  assign is_rd = pready & ~apb.pwrite;

  assign tx_push = is_wr & legal & (off == OFF_TXDATA) & ~tx_full;
  assign rx_pop  = is_rd & legal & (off == OFF_RXDATA) & ~rx_empty;
  assign err     = (pready & ~legal)
                 | (is_wr & legal & (off == OFF_TXDATA) & tx_full)
                 | (is_rd & legal & (off == OFF_RXDATA) & rx_empty);

  assign tx_valid = ~tx_empty & ctrl[CTRL_TX_EN];
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & ctrl[CTRL_RX_EN];
  assign rx_ovr   = rx_push & rx_full & ~rx_pop;

  assign rx_en       = ctrl[CTRL_RX_EN];
  assign apb.pready  = pready;
  assign apb.pslverr = err;
  assign apb.prdata  = err ? 32'h0 : rd_word;

  // Bus handshake: setup opens ACCESS, counter paces pready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (apb.psel & ~apb.penable) begin
            state <= ACCESS;
            wcnt  <= '0;
          end
        end
        ACCESS: begin
          if (~apb.psel)         state <= IDLE;
          else if (~apb.penable) wcnt  <= '0;
          else if (pready)       state <= IDLE;
          else                   wcnt  <= wcnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data mux, only meaningful on a completing read
  always_comb begin
    rd_word = 32'h0;
    if (is_rd & legal) begin
      unique case (off)
        OFF_CTRL:   rd_word = {28'h0, ctrl};
        OFF_BAUD:   rd_word = {16'h0, baud_div};
        OFF_STATUS: rd_word = {16'h0, 8'(rx_count), 3'b0, overrun,
                               rx_full, rx_empty, tx_empty, tx_full};
        OFF_RXDATA: rd_word = {24'h0, rx_head};
        default:    rd_word = 32'h0;
      endcase
    end
  end

  // Control registers, sticky overrun and the interrupt flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      baud_div <= 16'(BAUD_RST);
      overrun  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (is_wr & legal) begin
        unique case (1'b1)
          off == OFF_CTRL: ctrl     <= apb.pwdata[3:0];
          off == OFF_BAUD: baud_div <= apb.pwdata[15:0];
          default: ;
        endcase
      end
      if (rx_ovr)
        overrun <= 1'b1;
      else if (is_wr & legal & (off == OFF_STATUS)
               & apb.pwdata[ST_OVERRUN])
        overrun <= 1'b0;
      irq <= (ctrl[CTRL_RX_IRQ] & ~rx_empty)
           | (ctrl[CTRL_TX_IRQ] & tx_empty)
           | overrun;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (apb.pwdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );
endmodule

// File: tb/tb_apb_uart_csr.sv
// Bench for apb_uart_csr: directed scenarios, then random
// traffic checked against a transaction-level register model.
module tb_apb_uart_csr;
  localparam int WS    = 1;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [15:0] baud_div;
  logic       rx_en;
  logic       irq;

  apb_uart_csr_if bus ();

  apb_uart_csr #(
    .WAIT_STATES (WS),
    .TX_DEPTH    (DEPTH),
    .RX_DEPTH    (DEPTH),
    .BAUD_RST    (868)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .apb      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_div (baud_div),
    .rx_en    (rx_en),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] last_rd;
  bit          last_err;

  // Reference model: registers as plain variables, FIFOs as queues
  logic [3:0]  m_ctrl;
  logic [15:0] m_baud;
  bit          m_ovr;
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_ctrl = 4'h0;
    m_baud = 16'd868;
    m_ovr  = 1'b0;
    m_tx.delete();
    m_rx.delete();
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(m_rx.size()), 3'b0, m_ovr,
            m_rx.size() == DEPTH, m_rx.size() == 0,
            m_tx.size() == 0, m_tx.size() == DEPTH};
  endfunction

  function automatic bit m_irq();
    return (m_ctrl[2] && m_rx.size() != 0)
        || (m_ctrl[3] && m_tx.size() == 0) || m_ovr;
  endfunction

  function automatic void m_rx_push(input logic [7:0] b);
    if (!m_ctrl[1]) return;
    if (m_rx.size() == DEPTH) m_ovr = 1'b1;
    else m_rx.push_back(b);
  endfunction

  function automatic void m_xfer(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data,
                                 output logic [31:0] rd, output bit err);
    logic [4:0] off;
    off = addr[4:0];
    rd  = 32'h0;
    err = 1'b0;
    if (addr[1:0] != 2'b00 || off > 5'h10) begin
      err = 1'b1;
      return;
    end
    case (off)
      5'h00: if (wr) m_ctrl = data[3:0]; else rd = {28'h0, m_ctrl};
      5'h04: if (wr) m_baud = data[15:0]; else rd = {16'h0, m_baud};
      5'h08: if (wr) begin
               if (data[4]) m_ovr = 1'b0;
             end else rd = m_status();
      5'h0C: if (wr) begin
               if (m_tx.size() == DEPTH) err = 1'b1;
               else m_tx.push_back(data[7:0]);
             end
      5'h10: if (!wr) begin
               if (m_rx.size() == 0) err = 1'b1;
               else rd = {24'h0, m_rx.pop_front()};
             end
      default: ;
    endcase
  endfunction

  // One APB transfer; with_rx fires an RX strobe in the completion cycle
  task automatic apb(input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input bit with_rx,
                     input logic [7:0] rxb);
    logic [31:0] erd;
    bit          eerr;
    int          n;
    bit          done;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
    n = 1;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      n++;
      if (bus.pready) begin
        done = 1'b1;
        chk("latency", n, WS + 2);
        m_xfer(wr, addr, data, erd, eerr);
        last_rd  = bus.prdata;
        last_err = bus.pslverr;
        chk(wr ? "wr_err" : "rd_err", bus.pslverr, eerr);
        if (!wr) chk("rdata", bus.prdata, erd);
        if (with_rx) begin
          rx_data  = rxb;
          rx_valid = 1'b1;
          m_rx_push(rxb);
        end
      end else begin
        chk("wait_quiet", bus.prdata == 0 && !bus.pslverr, 1);
      end
    end
    if (!done) chk("pready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    chk("pready_once", bus.pready, 0);
  endtask

  task automatic apb_w(input logic [31:0] addr, input logic [31:0] data);
    apb(1'b1, addr, data, 1'b0, 8'h0);
  endtask

  task automatic apb_r(input logic [31:0] addr);
    apb(1'b0, addr, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    m_rx_push(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    bit ev;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      ev = m_ctrl[0] && m_tx.size() > 0;
      chk("tx_valid", tx_valid, ev);
      if (ev) chk("tx_data", tx_data, m_tx[0]);
      @(posedge clk);
      if (ev) void'(m_tx.pop_front());
      #1;
      if (!ev) break;
    end
    tx_ready = 1'b0;
  endtask

  task automatic side_check();
    @(posedge clk);
    @(negedge clk);
    chk("irq", irq, m_irq());
    chk("baud_div", baud_div, m_baud);
    chk("rx_en", rx_en, m_ctrl[1]);
    chk("tx_valid_idle", tx_valid, m_ctrl[0] && m_tx.size() > 0);
  endtask

  task automatic abort_xfer(input logic [31:0] addr,
                            input logic [31:0] data);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.pwrite = 1'b1; bus.paddr = addr; bus.pwdata = data;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    chk("abort_nordy", bus.pready, 0);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    chk("abort_idle", bus.pready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h0; bus.pwdata = 32'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready", bus.pready, 0);
    chk("rst_prdata", bus.prdata, 0);
    chk("rst_pslverr", bus.pslverr, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_baud", baud_div, 16'd868);
    chk("rst_rx_en", rx_en, 0);

    apb_r(32'h04);
    chk("baud_rst_rd", last_rd, 32'd868);
    apb_r(32'h08);
    chk("status_rst_rd", last_rd, 32'h6);

    apb_w(32'h00, 32'h1);
    apb_w(32'h0C, 32'hA5);
    apb_w(32'h0C, 32'h3C);
    drain();
    chk("tx_drained", tx_valid, 0);

    apb_w(32'h00, 32'h0);
    for (int i = 0; i < 9; i++) begin
      apb_w(32'h0C, 32'h10 + i);
      chk("tx_fill_err", last_err, i == 8);
    end
    apb_r(32'h08);
    chk("tx_full_bit", last_rd[0], 1);
    apb_w(32'h00, 32'h1);
    drain();

    apb_w(32'h00, 32'h6);
    for (int i = 0; i < 9; i++) rx_push(8'($urandom));
    side_check();
    apb_r(32'h08);
    chk("ovr_set", last_rd[4], 1);
    chk("rx_count8", last_rd[15:8], 8);
    apb_w(32'h08, 32'h10);
    apb_r(32'h08);
    chk("ovr_clr", last_rd[4], 0);
    apb(1'b0, 32'h10, 32'h0, 1'b1, 8'h77);
    apb_r(32'h08);
    chk("rx_cnt_pushpop", last_rd[15:8], 8);
    chk("no_ovr_pushpop", last_rd[4], 0);
    for (int i = 0; i < 8; i++) apb_r(32'h10);
    chk("rx_last_byte", last_rd, 32'h77);
    apb_r(32'h10);
    chk("rx_empty_err", last_err, 1);
    chk("rx_empty_data", last_rd, 0);

    apb_w(32'h14, 32'hF);
    chk("bad_off_err", last_err, 1);
    apb_r(32'h02);
    chk("misalign_err", last_err, 1);
    chk("misalign_data", last_rd, 0);
    apb_r(32'h00);
    abort_xfer(32'h0C, 32'h55);
    abort_xfer(32'h00, 32'hF);
    apb_r(32'h08);
    apb_r(32'h00);
    side_check();

    apb_w(32'h00, 32'h0);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0;
    bus.pwrite = 1'b1; bus.paddr = 32'h0C; bus.pwdata = 32'hEE;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_pready", bus.pready, 0);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst = 1'b0;
    m_reset();
    apb_r(32'h08);
    chk("rst_mid_status", last_rd, 32'h6);
    apb_r(32'h00);
    chk("rst_mid_ctrl", last_rd, 0);

    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 6)) * 4;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if (op <= 5) apb($urandom_range(0, 1) == 1, a, $urandom, 1'b0, 8'h0);
      else if (op == 6) rx_push(8'($urandom));
      else if (op == 7) drain();
      else if (op == 8) side_check();
      else apb($urandom_range(0, 1) == 1, a, $urandom, 1'b1, 8'($urandom));
    end
    side_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
